param_stack_unit: RTL and testbench
===================================

Name: param_stack_unit

Overview:
- Parametrised data stack for the stack processor. It replaces the fixed stack storage behind the stack-write-data path.
- It takes the 3-bit stackOP from control and the muxed stackWriteData (sign-extended immediate, shifted immediate, memory dout or ALU result).
- It presents top-of-stack and second-of-stack to the ALU and memory address path.
- It adds depth tracking, compound ALU-style ops and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 16: number of stack entries; must be at least 2.
- CNT_W, derived as ceil(log2(DEPTH+1)): width of the occupancy count. Local, not overridable.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stackOP  input  3  operation select, sampled every rising edge.
- writeData  input  WIDTH  data for PUSH, REPLACE and POP2_PUSH.
- top  output  WIDTH  entry at depth 0; 0 when count==0.
- second  output  WIDTH  entry at depth 1; 0 when count<2.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set by an illegal grow.
- underflow  output  1  sticky; set by an illegal shrink.
- opError  output  1  one-cycle pulse in the cycle after any rejected op.

Behaviour:
- Reset, when reset is high at the clock edge:
  - count=0, overflow=0, underflow=0, opError=0.
  - Storage contents are don't-care, because top and second are masked to 0.
  - Reset dominates any stackOP in the same cycle, including mid-sequence.
- top, second, empty and full are combinational from the registered state. An op's effect is visible the cycle after its edge (1-cycle latency).
- stackOP encoding, with the precondition each op needs:
  - 000 NOP: no change; no precondition.
  - 001 PUSH: new top = writeData, count+1. Requires not full.
  - 010 POP: count-1. Requires count>=1.
  - 011 REPLACE: top = writeData, count unchanged. Requires count>=1.
  - 100 POP2_PUSH (binary ALU result): remove top and second, push writeData, net count-1. Requires count>=2.
  - 101 SWAP: exchange top and second. Requires count>=2.
  - 110 DUP: push a copy of top, count+1. Requires count>=1 and not full.
  - 111 CLEAR: count=0, overflow=0, underflow=0. Always legal.
- Rejected op:
  - Stack contents and count are unchanged.
  - opError=1 for exactly one cycle.
  - A grow rejected for full sets overflow.
  - A shrink, or an op rejected for insufficient count, sets underflow.
  - DUP on an empty stack sets underflow, not overflow.
- Sticky flags clear only on reset or CLEAR. A legal op never clears them.
- opError deasserts in the cycle after the pulse unless the next op is also rejected.
- Entries below depth 1 are never modified by REPLACE, SWAP or POP2_PUSH.
- Arithmetic:
  - count never exceeds DEPTH and never goes below 0.
  - Internal pointers wrap modulo DEPTH, with no out-of-range array index.

Optional Feature:
- Macro: PARAM_STACK_WRAP_EN.
- When defined:
  - Storage is a circular buffer.
  - PUSH or DUP when full overwrites the oldest entry; count stays DEPTH.
  - The op is accepted: no overflow, no opError.
  - Underflow rules are unchanged.
- When undefined: full-stack grows are rejected as described in Behaviour.

Test Plan:
1. Reset, then PUSH 0x0005, PUSH 0x00A0, NOP → top=0x00A0, second=0x0005, count=2, all flags 0. Assert reset with PUSH 0x1111 on the same edge → count=0, top=0.
2. From [0x0005, 0x00A0], with 0x00A0 on top:
   - SWAP → top=0x0005, second=0x00A0.
   - POP2_PUSH 0x00A5 → top=0x00A5, count=1, second=0.
3. Empty stack, POP → count stays 0, underflow=1, opError high for one cycle only. Then PUSH 0x0007 → accepted, underflow still 1. Then CLEAR → underflow=0, count=0.
4. DEPTH=4, PUSH 1,2,3,4 → full=1. Then PUSH 5, with the macro undefined → count=4, top=4, overflow=1. POP×4 → tops 4,3,2,1 in turn, empty=1.
5. Same sequence with PARAM_STACK_WRAP_EN defined → after PUSH 5, top=5, count=4, overflow=0. POP×4 → tops 5,4,3,2.
6. count=1, apply REPLACE 0xBEEF → top=0xBEEF, no error. Then SWAP → rejected, underflow=1, top=0xBEEF. Then DUP → count=2, top=second=0xBEEF.

Source files
------------

// File: rtl/param_stack_unit.sv
// Parametrised data stack: top/second taps, occupancy count, compound ops, sticky error flags.
// Optional macro PARAM_STACK_WRAP_EN turns storage into a circular buffer that overwrites the oldest entry when full.
module param_stack_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                             CLK,
   input  logic                             reset,
   input  logic [2:0]                       stackOP,
   input  logic [WIDTH-1:0]                 writeData,
   output logic [WIDTH-1:0]                 top,
   output logic [WIDTH-1:0]                 second,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             empty,
   output logic                             full,
   output logic                             overflow,
   output logic                             underflow,
   output logic                             opError
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

`ifdef PARAM_STACK_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      OP_NOP       = 3'b000,
      OP_PUSH      = 3'b001,
      OP_POP       = 3'b010,
      OP_REPLACE   = 3'b011,
      OP_POP2_PUSH = 3'b100,
      OP_SWAP      = 3'b101,
      OP_DUP       = 3'b110,
      OP_CLEAR     = 3'b111
   } op_e;

   // Pointers move modulo DEPTH so the array index never leaves range, even for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      ptr_dec = (p == PTR_W'(0)) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
   endfunction

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] top_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             overflow_r;
   logic             underflow_r;
   logic             op_error_r;

   logic [PTR_W-1:0] sec_ptr_s;
   logic [WIDTH-1:0] top_raw_s;
   logic [WIDTH-1:0] sec_raw_s;
   logic             empty_s;
   logic             full_s;
   logic             two_s;

   logic [CNT_W-1:0] cnt_nxt_s;
   logic [PTR_W-1:0] ptr_nxt_s;
   logic             we_a_s;
   logic [PTR_W-1:0] wa_a_s;
   logic [WIDTH-1:0] wd_a_s;
   logic             we_b_s;
   logic [PTR_W-1:0] wa_b_s;
   logic [WIDTH-1:0] wd_b_s;
   logic             reject_s;
   logic             set_ovf_s;
   logic             set_unf_s;
   logic             clear_s;

   assign sec_ptr_s = ptr_dec(top_ptr_r);
   assign top_raw_s = mem_r[top_ptr_r];
   assign sec_raw_s = mem_r[sec_ptr_s];
   assign empty_s   = (count_r == CNT_W'(0));
   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign two_s     = (count_r >= CNT_W'(2));

   // Decode the op against the current occupancy into count/pointer updates, writes and error flags.
   always_comb begin
      cnt_nxt_s = count_r;
      ptr_nxt_s = top_ptr_r;
      we_a_s    = 1'b0;
      wa_a_s    = top_ptr_r;
      wd_a_s    = writeData;
      we_b_s    = 1'b0;
      wa_b_s    = sec_ptr_s;
      wd_b_s    = top_raw_s;
      reject_s  = 1'b0;
      set_ovf_s = 1'b0;
      set_unf_s = 1'b0;
      clear_s   = 1'b0;
      case (op_e'(stackOP))
         OP_NOP: begin
            cnt_nxt_s = count_r;
         end
         OP_PUSH, OP_DUP: begin
            if ((op_e'(stackOP) == OP_DUP) && empty_s) begin
               reject_s  = 1'b1;
               set_unf_s = 1'b1;
            end else if (full_s && !WRAP_EN) begin
               reject_s  = 1'b1;
               set_ovf_s = 1'b1;
            end else begin
               // In wrap mode a full push lands on the oldest slot, so count saturates at DEPTH.
               ptr_nxt_s = ptr_inc(top_ptr_r);
               we_a_s    = 1'b1;
               wa_a_s    = ptr_inc(top_ptr_r);
               wd_a_s    = (op_e'(stackOP) == OP_DUP) ? top_raw_s : writeData;
               cnt_nxt_s = full_s ? count_r : count_r + CNT_W'(1);
            end
         end
         OP_POP: begin
            if (empty_s) begin
               reject_s  = 1'b1;
               set_unf_s = 1'b1;
            end else begin
               ptr_nxt_s = sec_ptr_s;
               cnt_nxt_s = count_r - CNT_W'(1);
            end
         end
         OP_REPLACE: begin
            if (empty_s) begin
               reject_s  = 1'b1;
               set_unf_s = 1'b1;
            end else begin
               we_a_s = 1'b1;
            end
         end
         OP_POP2_PUSH: begin
            if (!two_s) begin
               reject_s  = 1'b1;
               set_unf_s = 1'b1;
            end else begin
               ptr_nxt_s = sec_ptr_s;
               we_a_s    = 1'b1;
               wa_a_s    = sec_ptr_s;
               cnt_nxt_s = count_r - CNT_W'(1);
            end
         end
         OP_SWAP: begin
            if (!two_s) begin
               reject_s  = 1'b1;
               set_unf_s = 1'b1;
            end else begin
               we_a_s = 1'b1;
               wd_a_s = sec_raw_s;
               we_b_s = 1'b1;
            end
         end
         OP_CLEAR: begin
            cnt_nxt_s = CNT_W'(0);
            clear_s   = 1'b1;
         end
         default: begin
            cnt_nxt_s = count_r;
         end
      endcase
   end

   // Control state: occupancy, top pointer, sticky flags and the one-cycle error pulse.
   always_ff @(posedge CLK) begin
      if (reset) begin
         count_r     <= CNT_W'(0);
         top_ptr_r   <= PTR_W'(0);
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         op_error_r  <= 1'b0;
      end else begin
         count_r     <= cnt_nxt_s;
         top_ptr_r   <= ptr_nxt_s;
         overflow_r  <= clear_s ? 1'b0 : (overflow_r | set_ovf_s);
         underflow_r <= clear_s ? 1'b0 : (underflow_r | set_unf_s);
         op_error_r  <= reject_s;
      end
   end

   // Storage writes; contents are left alone during reset since outputs are masked by count.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         if (we_a_s) begin
            mem_r[wa_a_s] <= wd_a_s;
         end
         if (we_b_s) begin
            mem_r[wa_b_s] <= wd_b_s;
         end
      end
   end

   assign top       = empty_s ? WIDTH'(0) : top_raw_s;
   assign second    = two_s ? sec_raw_s : WIDTH'(0);
   assign count     = count_r;
   assign empty     = empty_s;
   assign full      = full_s;
   assign overflow  = overflow_r;
   assign underflow = underflow_r;
   assign opError   = op_error_r;

endmodule

// File: tb/tb_param_stack_unit.sv
// Scoreboard bench for param_stack_unit (DEPTH=4): driver queues hand-computed results, monitor compares after each edge.
module tb_param_stack_unit;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef PARAM_STACK_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011,
                          P2P = 3'b100, SWAP = 3'b101, DUP  = 3'b110, CLR  = 3'b111;

   logic             CLK = 1'b0;
   logic             reset;
   logic [2:0]       stackOP;
   logic [WIDTH-1:0] writeData;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] second;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
   logic             opError;

   param_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .reset(reset), .stackOP(stackOP), .writeData(writeData),
      .top(top), .second(second), .count(count), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow), .opError(opError)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [WIDTH-1:0] top;
      logic [WIDTH-1:0] second;
      logic [CNT_W-1:0] count;
      logic             empty;
      logic             full;
      logic             ovf;
      logic             unf;
      logic             err;
   } obs_t;

   typedef struct {
      obs_t  exp;
      string name;
   } item_t;

   item_t q[$];
   int    checks = 0;
   int    errors = 0;

   // Apply one op for one edge and queue the state expected after that edge.
   task automatic step(input logic rst, input logic [2:0] op, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] et, input logic [WIDTH-1:0] es, input int ec,
                       input logic ef, input logic eo, input logic eu, input logic ee,
                       input string name);
      item_t it;
      @(negedge CLK);
      reset     = rst;
      stackOP   = op;
      writeData = d;
      it.exp    = '{top: et, second: es, count: CNT_W'(ec), empty: (ec == 0),
                    full: ef, ovf: eo, unf: eu, err: ee};
      it.name   = name;
      q.push_back(it);
   endtask

   // Monitor: every edge the DUT presents new state; compare it to the oldest queued expectation.
   initial begin
      item_t it;
      obs_t  act;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            it  = q.pop_front();
            act = '{top: top, second: second, count: count, empty: empty, full: full,
                    ovf: overflow, unf: underflow, err: opError};
            checks++;
            if (act !== it.exp) begin
               errors++;
               $display("FAIL %s: got top=%h sec=%h cnt=%0d e=%b f=%b ovf=%b unf=%b err=%b, want top=%h sec=%h cnt=%0d e=%b f=%b ovf=%b unf=%b err=%b",
                        it.name, act.top, act.second, act.count, act.empty, act.full, act.ovf, act.unf, act.err,
                        it.exp.top, it.exp.second, it.exp.count, it.exp.empty, it.exp.full, it.exp.ovf, it.exp.unf, it.exp.err);
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      reset = 1'b1; stackOP = NOP; writeData = 16'h0000;
      //    rst   op    data      top       second    cnt full ovf unf err
      step(1'b1, NOP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
      step(1'b0, PUSH, 16'h0005, 16'h0005, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "push5");
      step(1'b0, PUSH, 16'h00A0, 16'h00A0, 16'h0005, 2, 1'b0, 1'b0, 1'b0, 1'b0, "pushA0");
      step(1'b0, NOP,  16'h0000, 16'h00A0, 16'h0005, 2, 1'b0, 1'b0, 1'b0, 1'b0, "nop_hold");
      step(1'b1, PUSH, 16'h1111, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_beats_push");
      step(1'b0, PUSH, 16'h0005, 16'h0005, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "t2_push5");
      step(1'b0, PUSH, 16'h00A0, 16'h00A0, 16'h0005, 2, 1'b0, 1'b0, 1'b0, 1'b0, "t2_pushA0");
      step(1'b0, SWAP, 16'h0000, 16'h0005, 16'h00A0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "swap");
      step(1'b0, P2P,  16'h00A5, 16'h00A5, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "pop2_push");
      step(1'b0, CLR,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_t3");
      step(1'b0, POP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, "pop_empty");
      step(1'b0, NOP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, "operr_one_cycle");
      step(1'b0, PUSH, 16'h0007, 16'h0007, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 1'b0, "push_keeps_unf");
      step(1'b0, CLR,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_unf");
      step(1'b0, PUSH, 16'h0001, 16'h0001, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "fill1");
      step(1'b0, PUSH, 16'h0002, 16'h0002, 16'h0001, 2, 1'b0, 1'b0, 1'b0, 1'b0, "fill2");
      step(1'b0, PUSH, 16'h0003, 16'h0003, 16'h0002, 3, 1'b0, 1'b0, 1'b0, 1'b0, "fill3");
      step(1'b0, PUSH, 16'h0004, 16'h0004, 16'h0003, 4, 1'b1, 1'b0, 1'b0, 1'b0, "fill4_full");
      if (WRAP) begin
         step(1'b0, PUSH, 16'h0005, 16'h0005, 16'h0004, 4, 1'b1, 1'b0, 1'b0, 1'b0, "push_full_wrap");
         step(1'b0, POP,  16'h0000, 16'h0004, 16'h0003, 3, 1'b0, 1'b0, 1'b0, 1'b0, "pop_a");
         step(1'b0, POP,  16'h0000, 16'h0003, 16'h0002, 2, 1'b0, 1'b0, 1'b0, 1'b0, "pop_b");
         step(1'b0, POP,  16'h0000, 16'h0002, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "pop_c");
         step(1'b0, POP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "pop_d");
      end else begin
         step(1'b0, PUSH, 16'h0005, 16'h0004, 16'h0003, 4, 1'b1, 1'b1, 1'b0, 1'b1, "push_full_reject");
         step(1'b0, POP,  16'h0000, 16'h0003, 16'h0002, 3, 1'b0, 1'b1, 1'b0, 1'b0, "pop_a");
         step(1'b0, POP,  16'h0000, 16'h0002, 16'h0001, 2, 1'b0, 1'b1, 1'b0, 1'b0, "pop_b");
         step(1'b0, POP,  16'h0000, 16'h0001, 16'h0000, 1, 1'b0, 1'b1, 1'b0, 1'b0, "pop_c");
         step(1'b0, POP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, "pop_d");
      end
      step(1'b0, CLR,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_t6");
      step(1'b0, PUSH, 16'h1234, 16'h1234, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_push");
      step(1'b0, REPL, 16'hBEEF, 16'hBEEF, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, "replace");
      step(1'b0, SWAP, 16'h0000, 16'hBEEF, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 1'b1, "swap_reject");
      step(1'b0, DUP,  16'h0000, 16'hBEEF, 16'hBEEF, 2, 1'b0, 1'b0, 1'b1, 1'b0, "dup");
      step(1'b1, NOP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_clears_flags");
      step(1'b0, DUP,  16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, "dup_empty_unf");
      step(1'b0, P2P,  16'h9999, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, "p2p_reject_back2back");
      step(1'b0, PUSH, 16'h0042, 16'h0042, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 1'b0, "push_after_reject");
      step(1'b0, P2P,  16'h7777, 16'h0042, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 1'b1, "p2p_one_reject");
      step(1'b0, REPL, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 1'b0, "replace_zero");
      @(negedge CLK);
      stackOP = NOP;
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(negedge CLK);
         wait_cyc++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
